// File: rtl/lag_tile_inject_arbiter_pkg.sv
// Shared router types and parameters used by the tile injection arbiter.
package lag_tile_inject_arbiter_pkg;

    localparam int router_num_pls_on_entry = 2;
    localparam int FLIT_DATA_W             = 16;

    typedef logic [FLIT_DATA_W-1:0] flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } inj_state_t;

    // $clog2 clamped to at least one bit, for index fields of tiny vectors.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lag_tile_inject_arbiter_if.sv
// Requester-side handshake plus router tile-port signals of the injection arbiter.
interface lag_tile_inject_arbiter_if
    import lag_tile_inject_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NPL_ENTRY = router_num_pls_on_entry,
    parameter int FLIT_W    = $bits(flit_t),
    parameter int PL_W      = int'(min1_clog2(NPL_ENTRY))
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FLIT_W-1:0] req_flit;
    logic [NREQ-1:0]        req_head;
    logic [NREQ-1:0]        req_tail;
    logic [NREQ-1:0]        req_ready;
    logic [NPL_ENTRY-1:0]   input_full_flag;
    logic                   out_valid;
    logic [FLIT_W-1:0]      out_flit;
    logic [PL_W-1:0]        out_pl;
    logic                   busy;

    // Sources and router side.
    modport master (
        output req_valid, req_flit, req_head, req_tail, input_full_flag,
        input  req_ready, out_valid, out_flit, out_pl, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_flit, req_head, req_tail, input_full_flag,
        output req_ready, out_valid, out_flit, out_pl, busy
    );

endinterface

// File: rtl/lag_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module lag_rr_pick
    import lag_tile_inject_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = int'(min1_clog2(N))
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin : pick_scan
        int idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/lag_tile_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router tile port among NREQ sources,
// choosing a free entry PL per packet and issuing one registered flit per cycle.
module lag_tile_inject_arbiter
    import lag_tile_inject_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NPL_ENTRY = router_num_pls_on_entry,
    parameter int FLIT_W    = $bits(flit_t),
    parameter int PL_W      = int'(min1_clog2(NPL_ENTRY))
) (
    input  logic                      clk,
    input  logic                      rst_n,
    lag_tile_inject_arbiter_if.slave  bus
);

    localparam int REQ_W = int'(min1_clog2(NREQ));

    inj_state_t        state_q, state_d;
    logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]  locked_req_q, locked_req_d;
    logic [PL_W-1:0]   locked_pl_q, locked_pl_d;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic [PL_W-1:0]   out_pl_q;

    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   pick_onehot;
    logic [REQ_W-1:0]  pick_idx;
    logic              pick_any;
    logic              pl_free;
    logic [PL_W-1:0]   pl_idx;
    logic [NREQ-1:0]   ready;
    logic              accept;
    logic [REQ_W-1:0]  sel_req;
    logic [PL_W-1:0]   sel_pl;
    logic [FLIT_W-1:0] sel_flit;

    function automatic logic [REQ_W-1:0] next_ptr(input logic [REQ_W-1:0] idx);
        if (idx == REQ_W'(NREQ - 1)) return '0;
        return idx + 1'b1;
    endfunction

    // Only head flits may open a packet; stray body flits in IDLE are ignored.
    assign cand = bus.req_valid & bus.req_head;

    lag_rr_pick #(.N(NREQ), .W(REQ_W)) u_pick (
        .req        (cand),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        pl_free = 1'b0;
        pl_idx  = '0;
        for (int p = NPL_ENTRY - 1; p >= 0; p--) begin
            if (!bus.input_full_flag[p]) begin
                pl_free = 1'b1;
                pl_idx  = p[PL_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        locked_req_d = locked_req_q;
        locked_pl_d  = locked_pl_q;
        ready        = '0;
        accept       = 1'b0;
        sel_req      = locked_req_q;
        sel_pl       = locked_pl_q;
        case (state_q)
            IDLE: begin
                sel_req = pick_idx;
                sel_pl  = pl_idx;
                if (pick_any && pl_free) begin
                    accept       = 1'b1;
                    ready        = pick_onehot;
                    locked_req_d = pick_idx;
                    locked_pl_d  = pl_idx;
                    if (bus.req_tail[pick_idx]) rr_ptr_d = next_ptr(pick_idx);
                    else                        state_d  = LOCKED;
                end
            end
            LOCKED: begin
                // The packet stays pinned to its PL even if another one is free.
                if (bus.req_valid[locked_req_q] && !bus.input_full_flag[locked_pl_q]) begin
                    accept              = 1'b1;
                    ready[locked_req_q] = 1'b1;
                    if (bus.req_tail[locked_req_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr(locked_req_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_flit = bus.req_flit[sel_req*FLIT_W +: FLIT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            locked_req_q <= '0;
            locked_pl_q  <= '0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            out_pl_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            locked_req_q <= locked_req_d;
            locked_pl_q  <= locked_pl_d;
            out_valid_q  <= accept;
            if (accept) begin
                out_flit_q <= sel_flit;
                out_pl_q   <= sel_pl;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flit  = out_flit_q;
    assign bus.out_pl    = out_pl_q;
    assign bus.busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_lag_tile_inject_arbiter.sv
// Directed and randomized bench for the tile injection arbiter against a packet-level model.
module tb_lag_tile_inject_arbiter;
    import lag_tile_inject_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int NPL  = router_num_pls_on_entry;
    localparam int FW   = $bits(flit_t);
    localparam int PLW  = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lag_tile_inject_arbiter_if #(.NREQ(NREQ), .NPL_ENTRY(NPL), .FLIT_W(FW), .PL_W(PLW)) bus ();

    lag_tile_inject_arbiter #(.NREQ(NREQ), .NPL_ENTRY(NPL), .FLIT_W(FW), .PL_W(PLW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: current packet owner (-1 when none), its PL, and the next-turn pointer.
    int            owner, owner_pl, ptr;
    logic          exp_ov;
    logic [FW-1:0] exp_flit;
    int            exp_pl;
    logic [NREQ-1:0] m_rdy;
    bit            m_acc, m_tail;
    int            m_w, m_pl;
    logic [FW-1:0] m_flit;

    // Random source state.
    bit            act [NREQ];
    int            len [NREQ];
    int            pos [NREQ];
    int            waitc [NREQ];
    logic [FW-1:0] sflit [NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; owner_pl = 0; ptr = 0;
        exp_ov = 1'b0; exp_flit = '0; exp_pl = 0;
    endtask

    task automatic model_comb();
        m_rdy = '0; m_acc = 0; m_w = -1; m_pl = -1; m_tail = 0; m_flit = '0;
        if (owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (m_w < 0 && bus.req_valid[i] && bus.req_head[i]) m_w = i;
            end
            for (int p = 0; p < NPL; p++)
                if (m_pl < 0 && !bus.input_full_flag[p]) m_pl = p;
            m_acc = (m_w >= 0) && (m_pl >= 0);
        end else begin
            m_w = owner; m_pl = owner_pl;
            m_acc = bus.req_valid[owner] && !bus.input_full_flag[owner_pl];
        end
        if (m_acc) begin
            m_rdy[m_w] = 1'b1;
            m_tail     = bus.req_tail[m_w];
            m_flit     = bus.req_flit[m_w*FW +: FW];
        end
    endtask

    task automatic model_update();
        if (m_acc) begin
            exp_ov = 1'b1; exp_flit = m_flit; exp_pl = m_pl;
            if (owner < 0) begin
                if (m_tail) ptr = (m_w + 1) % NREQ;
                else begin owner = m_w; owner_pl = m_pl; end
            end else if (m_tail) begin
                ptr = (owner + 1) % NREQ;
                owner = -1;
            end
        end else begin
            exp_ov = 1'b0;
        end
    endtask

    // One clock: check combinational grant, clock it, check registered outputs.
    task automatic cycle();
        #1;
        model_comb();
        check("req_ready", bus.req_ready, m_rdy);
        checks++;
        assert ($countones(bus.req_ready) <= 1) else begin
            failures++;
            $error("FAIL onehot_ready observed=%0h expected=at_most_one", bus.req_ready);
        end
        @(posedge clk); #1;
        model_update();
        check("out_valid", bus.out_valid, exp_ov);
        check("busy", bus.busy, owner >= 0);
        check("out_flit", bus.out_flit, exp_flit);
        check("out_pl", bus.out_pl, exp_pl);
    endtask

    task automatic set_req(input int i, input bit v, input bit h, input bit t, input logic [FW-1:0] f);
        bus.req_valid[i]          = v;
        bus.req_head[i]           = h;
        bus.req_tail[i]           = t;
        bus.req_flit[i*FW +: FW]  = f;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0; bus.req_head = '0; bus.req_tail = '0; bus.req_flit = '0;
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        bus.input_full_flag = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_flit", bus.out_flit, 0);
        check("rst_out_pl", bus.out_pl, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);
        rst_n = 1'b1;

        // Single-flit packets from all four sources rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 1, FW'(16'h1000 + i));
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_grant", bus.req_ready, 32'(4'b0001 << exp_g[c]));
            cycle();
            check("rr_flit", bus.out_flit, 32'(16'h1000 + exp_g[c]));
        end
        clear_reqs();
        cycle();

        // Three-flit packet from req1 holds the port while req2 waits with a head.
        set_req(1, 1, 1, 0, 16'h2001);
        set_req(2, 1, 1, 1, 16'h2002);
        #1; check("lock_h", bus.req_ready, 4'b0010); cycle();
        set_req(1, 1, 0, 0, 16'h2011);
        #1; check("lock_b", bus.req_ready, 4'b0010); cycle();
        check("lock_busy", bus.busy, 1);
        check("lock_pl_b", bus.out_pl, 0);
        set_req(1, 1, 0, 1, 16'h2021);
        #1; check("lock_t", bus.req_ready, 4'b0010); cycle();
        check("lock_pl_t", bus.out_pl, 0);
        set_req(1, 0, 0, 0, 16'h0000);
        #1; check("lock_next", bus.req_ready, 4'b0100); cycle();
        check("lock_next_flit", bus.out_flit, 16'h2002);
        clear_reqs();

        // PL selection at the head, then stall while the locked PL is full.
        bus.input_full_flag = 2'b01;
        set_req(0, 1, 1, 0, 16'h3001);
        #1; check("pl_head", bus.req_ready, 4'b0001); cycle();
        check("pl_head_pl", bus.out_pl, 1);
        set_req(0, 1, 0, 0, 16'h3011);
        bus.input_full_flag = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1; check("pl_stall", bus.req_ready, 0); cycle();
            check("pl_stall_ov", bus.out_valid, 0);
        end
        bus.input_full_flag = 2'b00;
        #1; check("pl_body", bus.req_ready, 4'b0001); cycle();
        check("pl_body_pl", bus.out_pl, 1);
        set_req(0, 1, 0, 1, 16'h3021);
        bus.input_full_flag = 2'b01;
        cycle();
        check("pl_tail_pl", bus.out_pl, 1);
        clear_reqs();
        bus.input_full_flag = '0;

        // All PLs full: nothing moves, then the source at the pointer goes first.
        bus.input_full_flag = 2'b11;
        set_req(1, 1, 1, 1, 16'h4001);
        set_req(3, 1, 1, 1, 16'h4003);
        for (int c = 0; c < 5; c++) begin
            #1; check("full_ready", bus.req_ready, 0); cycle();
            check("full_ov", bus.out_valid, 0);
        end
        bus.input_full_flag = 2'b00;
        #1; check("full_release", bus.req_ready, 4'b0010); cycle();
        check("full_rel_flit", bus.out_flit, 16'h4001);
        set_req(1, 0, 0, 0, 16'h0000);
        cycle();
        clear_reqs();

        // Reset between body and tail abandons the packet.
        set_req(0, 1, 1, 0, 16'h5001); cycle();
        set_req(0, 1, 0, 0, 16'h5011); cycle();
        set_req(0, 1, 0, 1, 16'h5021);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.req_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1; check("orphan_tail", bus.req_ready, 0); cycle();
        set_req(0, 0, 0, 0, 16'h0000);
        set_req(2, 1, 1, 1, 16'h5002);
        #1; check("post_rst_head", bus.req_ready, 4'b0100); cycle();
        check("post_rst_flit", bus.out_flit, 16'h5002);
        clear_reqs();

        // Randomized traffic with backpressure.
        for (int i = 0; i < NREQ; i++) begin act[i] = 0; pos[i] = 0; len[i] = 1; waitc[i] = 0; end
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!act[i] && $urandom_range(2) == 0) begin
                    act[i] = 1; len[i] = $urandom_range(3, 1); pos[i] = 0; waitc[i] = 0;
                    sflit[i] = {i[3:0], 12'($urandom)};
                end
                if (act[i])
                    set_req(i, (pos[i] == 0) || ($urandom_range(3) != 0), pos[i] == 0,
                            pos[i] == len[i] - 1, sflit[i]);
                else
                    set_req(i, 0, 1'($urandom), 1'($urandom), FW'($urandom));
            end
            for (int p = 0; p < NPL; p++) bus.input_full_flag[p] = ($urandom_range(3) == 0);
            cycle();
            if (m_acc) begin
                if (pos[m_w] == 0) waitc[m_w] = 0;
                if (m_tail) begin
                    act[m_w] = 0;
                    for (int j = 0; j < NREQ; j++) begin
                        if (j != m_w && act[j] && pos[j] == 0) begin
                            waitc[j]++;
                            check("fair_wait", waitc[j] <= NREQ, 1);
                        end
                    end
                end else begin
                    pos[m_w]++;
                    sflit[m_w] = {m_w[3:0], 12'($urandom)};
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lag_tile_inject_arbiter.md
Name: lag_tile_inject_arbiter

Overview:
- Sits between NREQ local traffic sources in a tile and the tile (`TILE) input port of one mesh router.
- Shares that single injection port between the sources with packet-granular round-robin arbitration.
- Picks a free entry physical link (PL) per packet using the router's input_full_flag bits.
- Drives one registered flit per cycle into the router's tile-port din slice.

Parameters:
- NREQ, 4, number of local requesters (2..16)
- NPL_ENTRY, router_num_pls_on_entry, number of entry PLs the tile port exposes
- FLIT_W, $bits(flit_t), flit width in bits
- PL_W, $clog2(NPL_ENTRY) (min 1), width of the PL select field

Ports:
- clk  in  1  router clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i presents a flit
- req_flit  in  NREQ*FLIT_W  flit of requester i, slice [FLIT_W*(i+1)-1 : FLIT_W*i]
- req_head  in  NREQ  presented flit is a packet head
- req_tail  in  NREQ  presented flit is a packet tail (head and tail both set = single-flit packet)
- req_ready  out  NREQ  flit of requester i accepted this cycle
- input_full_flag  in  NPL_ENTRY  router entry PL p cannot take a flit
- out_valid  out  1  out_flit valid this cycle
- out_flit  out  FLIT_W  flit to the router tile port
- out_pl  out  PL_W  entry PL carrying out_flit
- busy  out  1  a packet is locked (state LOCKED)

Behaviour:
- Reset (async assert, sync-release use):
  - out_valid=0, out_flit=0, out_pl=0, busy=0.
  - state=IDLE, rr_ptr=0, locked_req=0, locked_pl=0.
- State IDLE:
  - Candidates are requesters i with req_valid[i]=1 and req_head[i]=1.
  - Winner is the first candidate scanning i = rr_ptr, rr_ptr+1, ... (mod NREQ).
  - PL is the lowest-index p with input_full_flag[p]=0.
  - Accept only if a winner and a free PL both exist:
    - req_ready[winner]=1; latch locked_req=winner and locked_pl=p.
    - If req_tail=0, go to LOCKED. If req_tail=1, stay IDLE and set rr_ptr=(winner+1) mod NREQ.
  - Requesters with valid=1 and head=0 while IDLE are never granted (protocol error). They get req_ready=0.
- State LOCKED:
  - Only locked_req may be accepted.
  - Condition: req_valid[locked_req]=1 and input_full_flag[locked_pl]=0, giving req_ready=1. Flits never switch PL mid-packet.
  - On an accepted flit with tail=1: go to IDLE and set rr_ptr=(locked_req+1) mod NREQ.
  - A head flit arriving while LOCKED is passed as data and does not restart arbitration.
- Output:
  - Registered, 1-cycle latency. Accept in cycle n gives out_valid=1, out_flit=req_flit, out_pl=selected PL in cycle n+1.
  - Without an accept, out_valid=0 next cycle. out_flit and out_pl hold their last value.
  - There is no ready from the router; input_full_flag is the only backpressure and is sampled in the accept cycle.
- req_ready is combinational from current inputs and state. At most one bit is set.
- busy = (state==LOCKED).
- Boundary cases:
  - All PLs full in IDLE: no grant, rr_ptr unchanged.
  - Locked PL full: stall with no grant. Other PLs are never used for this packet.
  - Only one requester valid: it is granted on every packet regardless of rr_ptr.
  - rr_ptr wraps from NREQ-1 to 0.
  - Reset mid-packet: returns to IDLE immediately. The partial packet is abandoned; the source must resend from its head.

Decomposition:
- Shared package (existing parameters/types package):
  - flit_t
  - router_num_pls_on_entry
  - a new typedef inj_state_t {IDLE, LOCKED}
- One sub-module: lag_rr_pick, a combinational rotating-priority picker.
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_onehot[N], gnt_idx, any.
  - Instantiated once for requesters. The PL selection is a plain priority encoder inline.

Test Plan:
- Single-flit packets: NREQ=4, all four requesters hold head+tail valid, full_flag=0 -> grants 0,1,2,3,0 on consecutive cycles; out_valid=1 from cycle 1 with matching out_flit.
- Packet lock: req1 sends a 3-flit packet (H,B,T) while req2 is valid with a head -> req1 gets 3 grants back-to-back; req2 is granted in the 4th cycle; out_pl is constant across req1's flits.
- PL selection and stall: NPL_ENTRY=2, full_flag=2'b01 at head -> out_pl=1. Then full_flag=2'b10 mid-packet -> req_ready=0 until bit1 clears; no flit appears on PL0.
- All full: full_flag=all ones with 2 heads waiting for 5 cycles -> req_ready=0 and out_valid=0 throughout. On release, the requester at rr_ptr is granted first.
- Reset mid-packet: assert rst_n=0 between the body and tail of a 3-flit packet -> out_valid=0, busy=0 immediately. After release, a non-head flit from the old owner gets req_ready=0; a new head from any requester is granted.
- Wrap and fairness: 1000 random cycles with random valid and full_flag -> no requester waits more than NREQ packet completions; at most one req_ready per cycle; a packet never changes PL.
